// File: rtl/sprot_xfer_arb.sv
// Round-robin arbiter sharing one sprot engine: grants a requester, drives start |=> a ##1 b,
// waits for xfer_end and returns done/err. Optional WAIT timeout via `SPROT_ARB_TIMEOUT_EN.
module sprot_xfer_arb #(
  parameter int NUM_REQ   = 4,
  parameter int TO_CYCLES = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] req_a_i,
  input  logic [NUM_REQ-1:0] req_b_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               err_o,
  output logic               timeout_o,
  output logic               busy_o,
  output logic               sp_start_o,
  output logic               sp_a_o,
  output logic               sp_b_o,
  input  logic               sp_prot_err_i,
  input  logic               sp_xfer_end_i,
  output logic [2:0]         state_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    A_PH  = 3'd2,
    B_PH  = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      g_q, g_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               a_q, a_d, b_q, b_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               sp_start_q, sp_start_d;
  logic               sp_a_q, sp_a_d;
  logic               sp_b_q, sp_b_d;

  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      cand_idx;
  int                 cand;

`ifdef SPROT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES);
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
`endif

  // First asserted request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(ptr_q) + i) % NUM_REQ;
      cand_idx = PW'(cand);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    g_d        = g_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    a_d        = a_q;
    b_d        = b_q;
    err_d      = err_q;
    sp_start_d = sp_start_q;
    sp_a_d     = sp_a_q;
    sp_b_d     = sp_b_q;
`ifdef SPROT_ARB_TIMEOUT_EN
    timer_d    = timer_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          g_d        = win_idx;
          gnt_d      = ONE << win_idx;
          a_d        = req_a_i[win_idx];
          b_d        = req_b_i[win_idx];
          sp_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        sp_start_d = 1'b0;
        sp_a_d     = a_q;
        state_d    = A_PH;
      end
      A_PH: begin
        sp_a_d  = 1'b0;
        sp_b_d  = b_q;
        state_d = B_PH;
      end
      B_PH: begin
        sp_b_d  = 1'b0;
`ifdef SPROT_ARB_TIMEOUT_EN
        timer_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // xfer_end takes priority over a simultaneous timer expiry.
        if (sp_xfer_end_i) begin
          done_d  = gnt_q;
          err_d   = sp_prot_err_i;
`ifdef SPROT_ARB_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef SPROT_ARB_TIMEOUT_EN
        else if (timer_q == TW'(TO_CYCLES - 1)) begin
          done_d    = gnt_q;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      RESP: begin
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
`ifdef SPROT_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        ptr_d   = (g_q == PW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      g_q        <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      sp_start_q <= 1'b0;
      sp_a_q     <= 1'b0;
      sp_b_q     <= 1'b0;
`ifdef SPROT_ARB_TIMEOUT_EN
      timer_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      g_q        <= g_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      a_q        <= a_d;
      b_q        <= b_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      sp_start_q <= sp_start_d;
      sp_a_q     <= sp_a_d;
      sp_b_q     <= sp_b_d;
`ifdef SPROT_ARB_TIMEOUT_EN
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign sp_start_o = sp_start_q;
  assign sp_a_o     = sp_a_q;
  assign sp_b_o     = sp_b_q;
  assign state_o    = state_q;
`ifdef SPROT_ARB_TIMEOUT_EN
  assign timeout_o  = timeout_q;
`else
  assign timeout_o  = 1'b0;
`endif

endmodule
